soml_frame_sequencer: RTL
=========================

Name: soml_frame_sequencer

Overview:
- Sequences soml_decoder_top: holds one 4x4 channel matrix H and reuses it across consecutive 4x2 Y blocks.
- Collects Y samples from upstream and issues the decoder start pulse. Then streams H and Y in parallel, waits for the decoder result, and hands it downstream with a valid/ready handshake tagged by a frame id.
- Sits between the front-end sample source and the decoder, replacing bench-driven stimulus in the integrated design.

Parameters:
N, 32, sample word width (Q-format signed, matches decoder N)
H_SIZE, 16, H entries per matrix (4x4)
Y_SIZE, 8, Y entries per block (4x2)
TIMEOUT_CYCLES, 4096, max cycles in WAIT_RES before abort
FID_W, 8, frame id width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
h_wr_valid  in  1  H sample write strobe
h_wr_ready  out  1  H write accepted when high with h_wr_valid
h_wr_r  in  N  H real part, row-major order
h_wr_i  in  N  H imag part
y_valid  in  1  Y sample valid
y_ready  out  1  Y sample accepted when high with y_valid
y_r  in  N  Y real part
y_i  in  N  Y imag part
dec_start  out  1  one-cycle start pulse to decoder
dec_H_in_valid  out  1  H stream valid
dec_H_in_r  out  N  H stream real
dec_H_in_i  out  N  H stream imag
dec_Y_in_valid  out  1  Y stream valid
dec_Y_in_r  out  N  Y stream real
dec_Y_in_i  out  N  Y stream imag
dec_output_valid  in  1  decoder result valid
dec_Smin_index  in  5  decoder min-metric index
dec_signal_out  in  12  decoder 12-bit output word
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_signal  out  12  captured dec_signal_out
res_index  out  5  captured dec_Smin_index
res_fid  out  FID_W  frame id of this result
h_loaded  out  1  full H matrix stored
busy  out  1  state != IDLE
timeout_err  out  1  sticky decoder-timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values: every output 0, state IDLE, h_cnt=0, y_cnt=0, fid=0, h_loaded=0. Reset mid-operation aborts immediately. Stored sample contents are don't-care after reset.
- H load (IDLE only):
  - h_wr_ready = (state==IDLE) & (y_cnt==0).
  - Each accepted write stores to H[h_cnt] and increments h_cnt.
  - The first write when h_loaded=1 clears h_loaded and restarts at index 0 (new matrix).
  - On the 16th write, h_cnt wraps to 0 and h_loaded=1 the next cycle.
- Y collect:
  - y_ready = (state==IDLE) & h_loaded & ~h_wr_valid. H write wins when both are offered.
  - Accepted samples store to Y[y_cnt].
  - On the 8th accept, y_cnt returns to 0 and the next state is START.
- States IDLE -> START -> GAP -> STREAM -> WAIT_RES -> HOLD_RES -> IDLE.
- START (1 cycle): dec_start=1.
- GAP (1 cycle): all dec_* outputs 0. This gives one idle cycle between the start sample edge and the first data edge.
- STREAM (16 cycles, k=0..15):
  - dec_H_in_valid=1 with H[k].
  - dec_Y_in_valid=1 with Y[k] for k<8, else 0.
  - Data outputs are 0 whenever the corresponding valid is 0.
  - Leaves to WAIT_RES after k=15.
- WAIT_RES:
  - Timer counts from 0.
  - First cycle with dec_output_valid=1: capture dec_signal_out and dec_Smin_index into res_*, res_fid=fid, go to HOLD_RES.
  - If the timer reaches TIMEOUT_CYCLES-1 without a valid: set timeout_err, increment fid, go to IDLE, produce no result.
  - Capture wins over timeout on the same cycle.
- HOLD_RES: res_valid=1 and res_* stable until res_ready. On handshake: fid increments (wraps 2^FID_W-1 -> 0), res_valid drops next cycle, go to IDLE.
- dec_output_valid outside WAIT_RES is ignored.
- timeout_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
- busy = (state != IDLE). All outputs are registered except h_wr_ready, y_ready and busy.

Decomposition:
- soml_seq_pkg holds:
  - the state enum (IDLE, START, GAP, STREAM, WAIT_RES, HOLD_RES);
  - H_SIZE, Y_SIZE;
  - count widths (H_CW=4, Y_CW=3);
  - result width constants (IDX_W=5, SIG_W=12).
- Sub-module soml_sample_buffer: parameterized DEPTH, single write port, single indexed read port, complex word of 2N. Instantiated twice (DEPTH=16 for H, DEPTH=8 for Y).

Test Plan:
- Load H 0x00010000..0x00100000 (16 writes), then 8 Y samples. Required: dec_start at cycle S, idle at S+1, H[0..15] on S+2..S+17, Y[0..7] on S+2..S+9, h_loaded=1 throughout.
- One H then 10 Y blocks with dec_output_valid returned 20 cycles after stream end, res_ready=1. Required: 10 results with res_fid 0..9, H re-streamed identically each frame.
- Hold res_ready=0 for 50 cycles after capture (index 5'd17, signal 12'hA5C). Required: res_valid stays high, values stable, y_ready=0, decoder sees no start.
- Never assert dec_output_valid. Required: timeout_err=1 exactly TIMEOUT_CYCLES cycles after WAIT_RES entry, no res_valid, fid increments. err_clr clears the flag.
- Assert rst during STREAM at k=6. Required: next cycle all dec_* valids 0, h_loaded=0, busy=0, y_ready=0 until a new H is loaded.
- Assert h_wr_valid and y_valid together in IDLE with h_loaded=1, y_cnt=0. Required: H write taken, y_ready=0, h_loaded clears.

Source files
------------

// File: rtl/soml_seq_pkg.sv
// Shared types and sizes for the SOML frame sequencer: FSM states, buffer
// depths, counter widths and decoder result widths.
package soml_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        STREAM,
        WAIT_RES,
        HOLD_RES
    } state_t;

    localparam int H_SIZE = 16;
    localparam int Y_SIZE = 8;
    localparam int H_CW   = 4;
    localparam int Y_CW   = 3;
    localparam int IDX_W  = 5;
    localparam int SIG_W  = 12;

endpackage

// File: rtl/soml_sample_buffer.sv
// Small complex-sample store: one write port, one combinational indexed read
// port, each word holding a {real, imag} pair of N-bit values.
module soml_sample_buffer #(
    parameter int N     = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_r,
    input  logic [N-1:0]  wr_i,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_r,
    output logic [N-1:0]  rd_i
);

    logic [2*N-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are only read after being written,
    // and resetting it would turn a RAM into a wide flop bank.
    // NOTE: sequential state uses non-blocking assignment so every reader sees
    // the pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_r, wr_i};
        end
    end

    assign {rd_r, rd_i} = mem[rd_addr];

endmodule

// File: rtl/soml_frame_sequencer.sv
// Feeds soml_decoder_top: keeps one H matrix, collects 4x2 Y blocks, streams
// both after a start pulse and returns the decoder result with a frame id.
module soml_frame_sequencer
    import soml_seq_pkg::*;
#(
    parameter int N              = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FID_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             h_wr_valid,
    output logic             h_wr_ready,
    input  logic [N-1:0]     h_wr_r,
    input  logic [N-1:0]     h_wr_i,
    input  logic             y_valid,
    output logic             y_ready,
    input  logic [N-1:0]     y_r,
    input  logic [N-1:0]     y_i,
    output logic             dec_start,
    output logic             dec_H_in_valid,
    output logic [N-1:0]     dec_H_in_r,
    output logic [N-1:0]     dec_H_in_i,
    output logic             dec_Y_in_valid,
    output logic [N-1:0]     dec_Y_in_r,
    output logic [N-1:0]     dec_Y_in_i,
    input  logic             dec_output_valid,
    input  logic [IDX_W-1:0] dec_Smin_index,
    input  logic [SIG_W-1:0] dec_signal_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SIG_W-1:0] res_signal,
    output logic [IDX_W-1:0] res_index,
    output logic [FID_W-1:0] res_fid,
    output logic             h_loaded,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t          state, state_nxt;
    logic [H_CW-1:0] h_cnt, k, k_nxt;
    logic [Y_CW-1:0] y_cnt;
    logic [TW-1:0]   timer;
    logic [FID_W-1:0] fid;

    logic h_acc, y_acc, capture, timeout_evt, res_hs;
    logic [N-1:0] h_rd_r, h_rd_i, y_rd_r, y_rd_i;

    logic         dec_start_d, h_valid_d, y_valid_d, res_valid_d;
    logic [N-1:0] h_r_d, h_i_d, y_r_d, y_i_d;

    assign h_wr_ready  = (state == IDLE) && (y_cnt == '0);
    assign y_ready     = (state == IDLE) && h_loaded && !h_wr_valid;
    assign busy        = (state != IDLE);
    assign h_acc       = h_wr_valid && h_wr_ready;
    assign y_acc       = y_valid && y_ready;
    assign capture     = (state == WAIT_RES) && dec_output_valid;
    assign timeout_evt = (state == WAIT_RES) && !dec_output_valid
                         && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign res_hs      = (state == HOLD_RES) && res_ready;

    soml_sample_buffer #(.N(N), .DEPTH(H_SIZE)) u_h_buf (
        .clk     (clk),
        .wr_en   (h_acc),
        .wr_addr (h_cnt),
        .wr_r    (h_wr_r),
        .wr_i    (h_wr_i),
        .rd_addr (k_nxt),
        .rd_r    (h_rd_r),
        .rd_i    (h_rd_i)
    );

    soml_sample_buffer #(.N(N), .DEPTH(Y_SIZE)) u_y_buf (
        .clk     (clk),
        .wr_en   (y_acc),
        .wr_addr (y_cnt),
        .wr_r    (y_r),
        .wr_i    (y_i),
        .rd_addr (k_nxt[Y_CW-1:0]),
        .rd_r    (y_rd_r),
        .rd_i    (y_rd_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (y_acc && y_cnt == Y_CW'(Y_SIZE - 1)) state_nxt = START;
            START:    state_nxt = GAP;
            GAP:      state_nxt = STREAM;
            STREAM:   if (k == H_CW'(H_SIZE - 1)) state_nxt = WAIT_RES;
            WAIT_RES: begin
                if (capture)          state_nxt = HOLD_RES;
                else if (timeout_evt) state_nxt = IDLE;
            end
            HOLD_RES: if (res_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        k_nxt = (state == STREAM && state_nxt == STREAM) ? k + 1'b1 : '0;
    end

    // Outputs are decoded from the next state and registered, so each
    // registered output lines up with the state it belongs to.
    always_comb begin
        dec_start_d = (state_nxt == START);
        h_valid_d   = (state_nxt == STREAM);
        y_valid_d   = h_valid_d && (k_nxt < H_CW'(Y_SIZE));
        res_valid_d = (state_nxt == HOLD_RES);
        h_r_d       = h_valid_d ? h_rd_r : '0;
        h_i_d       = h_valid_d ? h_rd_i : '0;
        y_r_d       = y_valid_d ? y_rd_r : '0;
        y_i_d       = y_valid_d ? y_rd_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_start      <= 1'b0;
            dec_H_in_valid <= 1'b0;
            dec_H_in_r     <= '0;
            dec_H_in_i     <= '0;
            dec_Y_in_valid <= 1'b0;
            dec_Y_in_r     <= '0;
            dec_Y_in_i     <= '0;
            res_valid      <= 1'b0;
        end else begin
            dec_start      <= dec_start_d;
            dec_H_in_valid <= h_valid_d;
            dec_H_in_r     <= h_r_d;
            dec_H_in_i     <= h_i_d;
            dec_Y_in_valid <= y_valid_d;
            dec_Y_in_r     <= y_r_d;
            dec_Y_in_i     <= y_i_d;
            res_valid      <= res_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            y_cnt       <= '0;
            k           <= '0;
            timer       <= '0;
            fid         <= '0;
            h_loaded    <= 1'b0;
            timeout_err <= 1'b0;
            res_signal  <= '0;
            res_index   <= '0;
            res_fid     <= '0;
        end else begin
            // A write into a complete matrix starts a new one at index 0,
            // which is where h_cnt already sits after the wrap.
            if (h_acc) begin
                if (h_cnt == H_CW'(H_SIZE - 1)) begin
                    h_cnt    <= '0;
                    h_loaded <= 1'b1;
                end else begin
                    h_cnt    <= h_cnt + 1'b1;
                    h_loaded <= 1'b0;
                end
            end
            if (y_acc) begin
                y_cnt <= (y_cnt == Y_CW'(Y_SIZE - 1)) ? '0 : y_cnt + 1'b1;
            end
            k     <= k_nxt;
            timer <= (state == WAIT_RES) ? timer + 1'b1 : '0;
            if (timeout_evt || res_hs) begin
                fid <= fid + 1'b1;
            end
            if (capture) begin
                res_signal <= dec_signal_out;
                res_index  <= dec_Smin_index;
                res_fid    <= fid;
            end
            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
